// File: rtl/sync_ptr_pkg.sv
// Shared types and helpers for the multi-channel Gray pointer synchronizer.
// gray2bin/bin2gray operate on 32-bit containers; callers slice to pointer width.
package sync_ptr_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic int ptr_w(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_ptr_multi_if.sv
// Pointer bundle between the foreign-domain producers and the rclk-domain consumer.
interface sync_ptr_multi_if
    import sync_ptr_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int NCH      = 4
);
    localparam int PW = ptr_w(ADDRSIZE);

    logic [NCH*PW-1:0] wptr_gray;
    logic              frz;
    logic [NCH*PW-1:0] rq_ptr_gray;
    logic [NCH*PW-1:0] rq_ptr_bin;
    logic [NCH-1:0]    rq_chg;
    logic              rq_any_chg;

    modport master (output wptr_gray, frz,
                    input  rq_ptr_gray, rq_ptr_bin, rq_chg, rq_any_chg);
    modport slave  (input  wptr_gray, frz,
                    output rq_ptr_gray, rq_ptr_bin, rq_chg, rq_any_chg);
endinterface

// File: rtl/sync_ptr_chan.sv
// One pointer channel: sync chain, registered Gray decode, change strobe.
// Optional multi-bit-step detector under SYNC_GRAY_CHECK_EN.
module sync_ptr_chan
    import sync_ptr_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_frz,
    input  logic [ADDRSIZE:0] i_gray,
    output logic [ADDRSIZE:0] o_gray,
    output logic [ADDRSIZE:0] o_bin,
    output logic            o_chg,
    output logic            o_chg_nxt
`ifdef SYNC_GRAY_CHECK_EN
    ,
    output logic            o_err
`endif
);
    localparam int PW = ptr_w(ADDRSIZE);

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_bin;
    logic          r_chg;
    logic [PW-1:0] w_gray;
    logic [PW-1:0] w_bin;
    logic [31:0]   w_bin32;
    logic          w_unused_hi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_gray;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_gray      = r_sync[SYNC_STAGES-1];
    assign w_bin32     = gray2bin(32'(w_gray));
    assign w_bin       = w_bin32[PW-1:0];
    assign w_unused_hi = ^w_bin32[31:PW];
    assign o_chg_nxt   = !i_frz && (w_bin != r_bin);

    // Freeze holds the decoded value; the chain above keeps tracking the source.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bin <= '0;
            r_chg <= 1'b0;
        end else begin
            r_chg <= o_chg_nxt;
            if (!i_frz) r_bin <= w_bin;
        end
    end

    assign o_gray = w_gray;
    assign o_bin  = r_bin;
    assign o_chg  = r_chg;

`ifdef SYNC_GRAY_CHECK_EN
    localparam int CW = $clog2(SYNC_STAGES + 2);

    logic [PW-1:0] r_prev;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [PW-1:0] w_diff;
    logic          w_armed;

    assign w_diff  = r_prev ^ w_gray;
    assign w_armed = (r_cnt == CW'(SYNC_STAGES + 1));

    // Masked until the reset flush of the chain has reached the comparator.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_prev <= w_gray;
            if (!w_armed) r_cnt <= r_cnt + 1'b1;
            if (w_armed && |(w_diff & (w_diff - 1'b1))) r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: rtl/sync_ptr_multi.sv
// NCH-channel Gray pointer synchronizer into the rclk domain.
// Define SYNC_GRAY_CHECK_EN to add the sticky gray_err output.
module sync_ptr_multi
    import sync_ptr_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic rclk,
    input  logic rrst,
`ifdef SYNC_GRAY_CHECK_EN
    output logic gray_err,
`endif
    sync_ptr_multi_if.slave bus
);
    localparam int PW = ptr_w(ADDRSIZE);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_depth
        $error("sync_ptr_multi: SYNC_STAGES must be at least 2");
    end

    logic [NCH-1:0][PW-1:0] w_gray;
    logic [NCH-1:0][PW-1:0] w_bin;
    logic [NCH-1:0]         w_chg;
    logic [NCH-1:0]         w_chg_nxt;
    logic                   r_any;
`ifdef SYNC_GRAY_CHECK_EN
    logic [NCH-1:0]         w_err;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        sync_ptr_chan #(
            .ADDRSIZE    (ADDRSIZE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .i_clk     (rclk),
            .i_rst     (rrst),
            .i_frz     (bus.frz),
            .i_gray    (bus.wptr_gray[c*PW +: PW]),
            .o_gray    (w_gray[c]),
            .o_bin     (w_bin[c]),
            .o_chg     (w_chg[c]),
            .o_chg_nxt (w_chg_nxt[c])
`ifdef SYNC_GRAY_CHECK_EN
            ,
            .o_err     (w_err[c])
`endif
        );
    end

    // Registered from the same next-state terms so it lines up with rq_chg.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) r_any <= 1'b0;
        else      r_any <= |w_chg_nxt;
    end

    assign bus.rq_ptr_gray = w_gray;
    assign bus.rq_ptr_bin  = w_bin;
    assign bus.rq_chg      = w_chg;
    assign bus.rq_any_chg  = r_any;
`ifdef SYNC_GRAY_CHECK_EN
    assign gray_err = |w_err;
`endif

endmodule

// File: tb/tb_sync_ptr_multi.sv
// Self-checking bench: three depths (2,3,4) share one stimulus stream and are
// checked every cycle against a latency/history model plus literal expectations.
module tb_sync_ptr_multi;
    import sync_ptr_pkg::*;

    localparam int PW = 5;
    localparam int NC = 4;
    localparam int W  = NC * PW;

    logic         rclk = 1'b0;
    logic         rrst = 1'b1;
    logic [W-1:0] wptr = '0;
    logic         frz  = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 rclk = ~rclk;

    sync_ptr_multi_if #(.ADDRSIZE(4), .NCH(NC)) b2 ();
    sync_ptr_multi_if #(.ADDRSIZE(4), .NCH(NC)) b3 ();
    sync_ptr_multi_if #(.ADDRSIZE(4), .NCH(NC)) b4 ();

    assign b2.wptr_gray = wptr;
    assign b3.wptr_gray = wptr;
    assign b4.wptr_gray = wptr;
    assign b2.frz = frz;
    assign b3.frz = frz;
    assign b4.frz = frz;

`ifdef SYNC_GRAY_CHECK_EN
    logic e2, e3, e4;
`endif

    sync_ptr_multi #(.ADDRSIZE(4), .NCH(NC), .SYNC_STAGES(2)) dut2 (
        .rclk(rclk), .rrst(rrst),
`ifdef SYNC_GRAY_CHECK_EN
        .gray_err(e2),
`endif
        .bus(b2));
    sync_ptr_multi #(.ADDRSIZE(4), .NCH(NC), .SYNC_STAGES(3)) dut3 (
        .rclk(rclk), .rrst(rrst),
`ifdef SYNC_GRAY_CHECK_EN
        .gray_err(e3),
`endif
        .bus(b3));
    sync_ptr_multi #(.ADDRSIZE(4), .NCH(NC), .SYNC_STAGES(4)) dut4 (
        .rclk(rclk), .rrst(rrst),
`ifdef SYNC_GRAY_CHECK_EN
        .gray_err(e4),
`endif
        .bus(b4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: input seen at edge n reaches rq_ptr_gray after S edges, the decode one later.
    int           n = 0;
    logic [W-1:0] hist [int];
    logic [W-1:0] eg [3];
    logic [W-1:0] eb [3];
    logic [NC-1:0] ec [3];
    logic         ea [3];

    function automatic logic [W-1:0] h(input int i);
        return (i >= 1 && hist.exists(i)) ? hist[i] : '0;
    endfunction

    function automatic logic [W-1:0] dec_all(input logic [W-1:0] g);
        logic [W-1:0] r;
        logic [31:0]  t;
        for (int c = 0; c < NC; c++) begin
            t = gray2bin(32'(g[c*PW +: PW]));
            r[c*PW +: PW] = t[PW-1:0];
        end
        return r;
    endfunction

    initial forever begin
        @(posedge rclk);
        if (rrst) begin
            n = 0;
            hist.delete();
            for (int k = 0; k < 3; k++) begin
                eg[k] = '0; eb[k] = '0; ec[k] = '0; ea[k] = 1'b0;
            end
        end else begin
            logic [W-1:0] nb;
            n++;
            hist[n] = wptr;
            for (int k = 0; k < 3; k++) begin
                eg[k] = h(n - (k + 2) + 1);
                nb = dec_all(h(n - (k + 2)));
                if (frz) ec[k] = '0;
                else begin
                    for (int c = 0; c < NC; c++)
                        ec[k][c] = (nb[c*PW +: PW] != eb[k][c*PW +: PW]);
                    eb[k] = nb;
                end
                ea[k] = |ec[k];
            end
        end
    end

    initial forever begin
        @(negedge rclk);
        if (!rrst && n > 0) begin
            chk("s2 gray", b2.rq_ptr_gray, eg[0]);
            chk("s2 bin",  b2.rq_ptr_bin,  eb[0]);
            chk("s2 chg",  b2.rq_chg,      ec[0]);
            chk("s2 any",  b2.rq_any_chg,  ea[0]);
            chk("s3 gray", b3.rq_ptr_gray, eg[1]);
            chk("s3 bin",  b3.rq_ptr_bin,  eb[1]);
            chk("s3 chg",  b3.rq_chg,      ec[1]);
            chk("s3 any",  b3.rq_any_chg,  ea[1]);
            chk("s4 gray", b4.rq_ptr_gray, eg[2]);
            chk("s4 bin",  b4.rq_ptr_bin,  eb[2]);
            chk("s4 chg",  b4.rq_chg,      ec[2]);
            chk("s4 any",  b4.rq_any_chg,  ea[2]);
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        int pulses, other;
        logic [31:0] g;

        // Reset with all-ones input, then release and watch the flush.
        wptr = '1;
        repeat (3) tick();
        chk("rst gray", b2.rq_ptr_gray, 0);
        chk("rst bin",  b4.rq_ptr_bin,  0);
        chk("rst chg",  b2.rq_chg,      0);
        chk("rst any",  b3.rq_any_chg,  0);
        rrst = 1'b0;
        tick();
        chk("e1 gray", b2.rq_ptr_gray, 0);
        tick();
        chk("e2 gray", b2.rq_ptr_gray, 20'hFFFFF);
        tick();
        chk("e3 bin", b2.rq_ptr_bin, {4{5'b10101}});
        chk("e3 chg", b2.rq_chg, 4'hF);
        chk("e3 any", b2.rq_any_chg, 1);

        // Restart from all-zero pointers.
        rrst = 1'b1;
        wptr = '0;
        repeat (2) tick();
        rrst = 1'b0;
        repeat (6) tick();

        // Latency sweep on channel 0.
        wptr[4:0] = 5'b00001;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("lat s2", b2.rq_chg[0], (t == 3));
            chk("lat s3", b3.rq_chg[0], (t == 4));
            chk("lat s4", b4.rq_chg[0], (t == 5));
        end
        chk("lat bin s2", b2.rq_ptr_bin[4:0], 1);
        chk("lat bin s4", b4.rq_ptr_bin[4:0], 1);

        // Channel 1 counts through the full range and wraps.
        pulses = 0;
        other  = 0;
        for (int b = 1; b <= 36; b++) begin
            if (b <= 32) begin
                g = bin2gray(32'(b % 32));
                wptr[9:5] = g[4:0];
            end
            tick();
            pulses += int'(b2.rq_chg[1]);
            if ((b2.rq_chg & 4'b1101) != 0) other++;
        end
        chk("wrap pulses", pulses, 32);
        chk("wrap other",  other,  0);
        chk("wrap bin",    b2.rq_ptr_bin[9:5], 0);

        // Freeze while channel 2 advances 3 -> 7.
        wptr[14:10] = 5'b00010;
        repeat (5) tick();
        frz = 1'b1;
        for (int v = 4; v <= 11; v++) begin
            if (v <= 7) begin
                g = bin2gray(32'(v));
                wptr[14:10] = g[4:0];
            end
            tick();
            chk("frz hold", b2.rq_ptr_bin[14:10], 3);
            chk("frz chg",  b2.rq_chg[2], 0);
        end
        frz = 1'b0;
        tick();
        chk("unfrz bin", b2.rq_ptr_bin[14:10], 7);
        chk("unfrz chg", b2.rq_chg, 4'b0100);
        tick();
        chk("unfrz once", b2.rq_chg[2], 0);

        // Channels 0 and 3 step together.
        wptr[4:0]   = 5'b00011;
        wptr[19:15] = 5'b00001;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk("simul chg", b2.rq_chg, (t == 3) ? 4'b1001 : 4'b0000);
            chk("simul any", b2.rq_any_chg, (t == 3));
        end

`ifdef SYNC_GRAY_CHECK_EN
        chk("err legal s2", e2, 0);
        chk("err legal s4", e4, 0);
        wptr[4:0] = 5'b00000;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("err s2", e2, (t >= 3));
            chk("err s3", e3, (t >= 4));
            chk("err s4", e4, (t >= 5));
        end
        repeat (3) tick();
        chk("err sticky", e2, 1);
`endif

        // Asynchronous reset mid-cycle clears everything immediately.
        @(negedge rclk);
        #1;
        rrst = 1'b1;
        #1;
        chk("arst gray", b2.rq_ptr_gray, 0);
        chk("arst bin",  b3.rq_ptr_bin,  0);
        chk("arst chg",  b4.rq_chg,      0);
`ifdef SYNC_GRAY_CHECK_EN
        chk("arst err", e2, 0);
`endif
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
